// File: rtl/snn_pkg.sv
// Shared constants and types for the leaky-neuron datapath.
// beta is a leak factor in eighths (BETA_ONE = unity), so the forward leak is
// (potential * beta) >> BETA_SHIFT and the inverse divider computes
// floor(potential * 8 / beta).
package snn_pkg;

  localparam int unsigned POT_W      = 8;
  localparam int unsigned BETA_W     = 4;
  localparam int unsigned BETA_ONE   = 8;
  localparam int unsigned BETA_SHIFT = 3;

  // Dividend is {potential, BETA_SHIFT zeros}; one quotient bit per step.
  localparam int unsigned DIV_STEPS  = POT_W + BETA_SHIFT;
  // Partial remainder needs one bit above the divisor for the compare.
  localparam int unsigned REM_W      = BETA_W + 1;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

endpackage

// File: rtl/shift_sub_div.sv
// Sequential restoring divider: div_ans = min(255, floor(potential * 8 / beta)).
// One quotient bit per clock, start/done handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      request, sampled only while idle
//   beta       leak factor in eighths, legal 1..8
//   potential  unsigned membrane potential
//   busy       high while calculating or presenting done
//   done       one-cycle pulse, result valid
//   div_ans    registered, saturated quotient
//   sat        quotient exceeded 255 and was clamped
//   err        beta outside 1..8
module shift_sub_div
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BETA_W-1:0] beta,
  input  logic [POT_W-1:0]  potential,
  output logic              busy,
  output logic              done,
  output logic [POT_W-1:0]  div_ans,
  output logic              sat,
  output logic              err
);

  div_state_e           state_q, state_d;
  logic [DIV_STEPS-1:0] dividend_q, dividend_d;
  logic [BETA_W-1:0]    divisor_q, divisor_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [DIV_STEPS-1:0] quot_q, quot_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [POT_W-1:0]     div_ans_q, div_ans_d;
  logic                 sat_q, sat_d;
  logic                 err_q, err_d;

  // One restoring step, computed every cycle and used only in StCalc.
  logic [REM_W-1:0]     rem_shift;
  logic                 rem_ge;
  logic [REM_W-1:0]     rem_step;
  logic [DIV_STEPS-1:0] quot_step;

  always_comb begin
    // Truncating casts drop the top bits, which are always zero / shifted out.
    rem_shift = REM_W'({rem_q, dividend_q[DIV_STEPS-1]});
    rem_ge    = (rem_shift >= {1'b0, divisor_q});
    rem_step  = rem_ge ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
    quot_step = DIV_STEPS'({quot_q, rem_ge});
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    div_ans_d  = div_ans_q;
    sat_d      = sat_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (beta == '0) begin
            // Division by zero reads as "infinitely large".
            div_ans_d = '1;
            sat_d     = 1'b0;
            err_d     = 1'b1;
            state_d   = StDone;
          end else if (beta > BETA_W'(BETA_ONE)) begin
            div_ans_d = '0;
            sat_d     = 1'b0;
            err_d     = 1'b1;
            state_d   = StDone;
          end else begin
            dividend_d = {potential, BETA_SHIFT'(0)};
            divisor_d  = beta;
            rem_d      = '0;
            quot_d     = '0;
            cnt_d      = CNT_W'(DIV_STEPS - 1);
            state_d    = StCalc;
          end
        end
      end

      StCalc: begin
        dividend_d = {dividend_q[DIV_STEPS-2:0], 1'b0};
        rem_d      = rem_step;
        quot_d     = quot_step;
        if (cnt_q == '0) begin
          if (quot_step[DIV_STEPS-1:POT_W] != '0) begin
            div_ans_d = '1;
            sat_d     = 1'b1;
          end else begin
            div_ans_d = quot_step[POT_W-1:0];
            sat_d     = 1'b0;
          end
          err_d   = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      div_ans_q  <= '0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      div_ans_q  <= div_ans_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign div_ans = div_ans_q;
  assign sat     = sat_q;
  assign err     = err_q;

endmodule

// File: tb/tb_shift_sub_div.sv
// Directed bench for shift_sub_div: latency, quotient, saturation, error path,
// start-while-busy, reset abort and an exhaustive potential x beta sweep.
module tb_shift_sub_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] beta;
  logic [7:0] potential;
  logic       busy;
  logic       done;
  logic [7:0] div_ans;
  logic       sat;
  logic       err;

  int tests = 0;
  int fails = 0;

  shift_sub_div dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .beta      (beta),
    .potential (potential),
    .busy      (busy),
    .done      (done),
    .div_ans   (div_ans),
    .sat       (sat),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Issue one request and return the cycle (1 = first cycle after the
  // accepting edge) in which done is seen; 20 means it never came.
  // Operands are scrambled right after acceptance.
  task automatic do_div(input logic [7:0] p, input logic [3:0] b, output int lat);
    @(negedge clk);
    start     = 1'b1;
    potential = p;
    beta      = b;
    @(negedge clk);
    start     = 1'b0;
    potential = ~p;
    beta      = b + 4'd3;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_q(input int p, input int b);
    int q;
    if (b == 0) return 255;
    if (b > 8) return 0;
    q = (p * 8) / b;
    return (q > 255) ? 255 : q;
  endfunction

  initial begin
    int lat;
    int seen;
    int rt;
    rst = 1'b1;
    start = 1'b0;
    beta = 4'd0;
    potential = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ans", div_ans, 0);
    check("rst_sat", sat, 0);
    check("rst_err", err, 0);

    // Reset and start together: reset wins.
    start = 1'b1;
    beta  = 4'd4;
    @(negedge clk);
    check("rst_start_busy", busy, 0);
    rst   = 1'b0;
    start = 1'b0;

    do_div(8'd100, 4'd4, lat);
    check("p100b4_lat", lat, 12);
    check("p100b4_ans", div_ans, 200);
    check("p100b4_sat", sat, 0);
    check("p100b4_err", err, 0);
    check("p100b4_busy", busy, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("hold_ans", div_ans, 200);

    do_div(8'd100, 4'd8, lat);
    check("p100b8_ans", div_ans, 100);
    do_div(8'd50, 4'd3, lat);
    check("p50b3_ans", div_ans, 133);
    do_div(8'd200, 4'd3, lat);
    check("p200b3_ans", div_ans, 255);
    check("p200b3_sat", sat, 1);
    do_div(8'd255, 4'd1, lat);
    check("p255b1_ans", div_ans, 255);
    check("p255b1_sat", sat, 1);
    check("p255b1_lat", lat, 12);

    do_div(8'd77, 4'd0, lat);
    check("b0_lat", lat, 1);
    check("b0_ans", div_ans, 255);
    check("b0_err", err, 1);
    check("b0_sat", sat, 0);
    do_div(8'd77, 4'd9, lat);
    check("b9_lat", lat, 1);
    check("b9_ans", div_ans, 0);
    check("b9_err", err, 1);

    // Start held high with an illegal beta: accepted on every return to idle.
    @(negedge clk);
    start = 1'b1;
    beta  = 4'd9;
    @(negedge clk);
    check("hold_c1", done, 1);
    @(negedge clk);
    check("hold_c2", done, 0);
    @(negedge clk);
    check("hold_c3", done, 1);
    start = 1'b0;
    @(negedge clk);
    check("hold_c4", done, 0);

    // Start pulse in the middle of a running op is ignored.
    @(negedge clk);
    start = 1'b1; potential = 8'd100; beta = 4'd4;
    @(negedge clk);                 // cycle 1
    start = 1'b0;
    repeat (4) @(negedge clk);      // cycle 5
    start = 1'b1; potential = 8'd10; beta = 4'd0;
    @(negedge clk);                 // cycle 6
    start = 1'b0;
    check("ignore_busy", busy, 1);
    lat = 6;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_lat", lat, 12);
    check("ignore_ans", div_ans, 200);
    check("ignore_err", err, 0);
    @(negedge clk);
    check("ignore_idle", busy, 0);

    // Reset in the middle of CALC aborts without a done pulse.
    do_div(8'd200, 4'd3, lat);      // leaves div_ans/sat nonzero
    @(negedge clk);
    start = 1'b1; potential = 8'd100; beta = 4'd4;
    @(negedge clk);                 // cycle 1
    start = 1'b0;
    repeat (4) @(negedge clk);      // cycle 5
    rst = 1'b1;
    @(negedge clk);                 // cycle 6
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ans", div_ans, 0);
    check("abort_sat", sat, 0);
    check("abort_err", err, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_nodone", seen, 0);
    do_div(8'd100, 4'd4, lat);
    check("after_rst_lat", lat, 12);
    check("after_rst_ans", div_ans, 200);

    // Sweep every potential x legal beta; check the forward-leak round trip.
    for (int b = 1; b <= 8; b++) begin
      for (int p = 0; p < 256; p++) begin
        do_div(8'(p), 4'(b), lat);
        check($sformatf("sweep_p%0d_b%0d", p, b), div_ans, ref_q(p, b));
        check($sformatf("sweep_sat_p%0d_b%0d", p, b), sat, ((p * 8) / b > 255) ? 1 : 0);
        if ((p * 8) / b <= 255) begin
          rt = (div_ans * b) >> 3;
          check($sformatf("roundtrip_p%0d_b%0d", p, b), ((p - rt) <= 1 && rt <= p) ? 1 : 0, 1);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
